// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA receive-side sync decoder: helpers that derive
// the line/frame totals and the counter widths from the mode parameters, and
// the lock-state encoding used by the lock FSM.
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SEEK     = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    // Total of the four timing segments (visible, front, sync, back).
    function automatic int total4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    // Counter width able to hold 0 .. total-1; never narrower than 1 bit.
    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop register stage for one sync pin plus assertion-edge detection.
// Ports:
//   clk     in   pixel clock
//   rst_n   in   synchronous active-low reset (stages load the deasserted level)
//   i_sync  in   raw sync pin, synchronous to clk
//   o_edge  out  high for one clk when stage 1 is asserted and stage 2 is not
// -----------------------------------------------------------------------------
module sync_edge_det #(
    parameter bit POL = 1'b0          // asserted level of the sync pin
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;

    // NOTE: non-blocking assignments make r_s2 take the pre-edge value of r_s1,
    // which is what turns the pair into a shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= ~POL;
            r_s2 <= ~POL;
        end else begin
            r_s1 <= i_sync;
            r_s2 <= r_s1;
        end
    end

    assign o_edge = (r_s1 == POL) && (r_s2 != POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side VGA timing recovery. Rebuilds the horizontal/vertical counters
// from hsync/vsync, checks line and frame length against the mode, runs a lock
// FSM and produces registered pixel coordinates, display enable and a
// frame-start marker.
// Ports:
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   hsync/vsync  in   sync pins, synchronous to clk, asserted level SYNC_POL
//   x / y        out  active-area column / row (0 outside the active area)
//   de           out  high on active pixels while locked
//   frame_start  out  one-clk pulse together with de on pixel (0,0)
//   locked       out  measured timing matches the mode
//   sync_err     out  one-clk pulse per detected timing violation
// h_cnt is 0 on the clk after the hsync assertion edge; v_cnt is 0 on the line
// that starts with the first hsync edge after a vsync edge.
// -----------------------------------------------------------------------------
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2,
    localparam int H_TOTAL    = total4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL    = total4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int HW         = cnt_width(H_TOTAL),
    localparam int VW         = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          de,
    output logic          frame_start,
    output logic          locked,
    output logic          sync_err
);

    localparam int GW = cnt_width(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] H_MAX    = '1;
    localparam logic [VW-1:0] V_MAX    = '1;
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LO = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_HI = HW'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [VW-1:0] V_ACT_LO = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_HI = VW'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_FRAMES);

    logic w_hedge;
    logic w_vedge;

    sync_edge_det #(.POL(SYNC_POL != 0)) u_hs_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sync (hsync),
        .o_edge (w_hedge)
    );

    sync_edge_det #(.POL(SYNC_POL != 0)) u_vs_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sync (vsync),
        .o_edge (w_vedge)
    );

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_v_pend;
    logic          r_h_seen;    // an hsync edge has been seen since reset
    logic          r_v_seen;    // a v_cnt reload has happened since reset
    logic          r_to_done;   // timeout already reported for this line
    logic          r_dirty;     // an error occurred since the last reload
    logic [GW-1:0] r_good;
    lock_state_e   r_state;

    logic [HW-1:0] r_x;
    logic [VW-1:0] r_y;
    logic          r_de;
    logic          r_fs;
    logic          r_locked;
    logic          r_err;

    // A pending (or coincident) vsync edge is applied at the next hsync edge so
    // that y never changes in the middle of a line.
    logic w_reload;
    logic w_line_err;
    logic w_frame_err;
    logic w_h_timeout;
    logic w_err;

    assign w_reload    = w_hedge && (r_v_pend || w_vedge);
    assign w_line_err  = w_hedge && r_h_seen && (r_h_cnt != H_LAST);
    assign w_frame_err = w_reload && r_v_seen && (r_v_cnt != V_LAST);
    assign w_h_timeout = !w_hedge && !r_to_done && (r_h_cnt == H_MAX);
    assign w_err       = w_line_err || w_frame_err || w_h_timeout;

    lock_state_e   w_state_next;
    logic [GW-1:0] w_good_next;
    logic [GW-1:0] w_good_inc;

    assign w_good_inc = r_good + 1'b1;

    // NOTE: every signal written here gets a default first, so no latch is
    // inferred for the paths that leave it untouched.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        case (r_state)
            UNLOCKED: begin
                if (w_reload) begin
                    w_state_next = SEEK;
                    w_good_next  = '0;
                end
            end
            SEEK: begin
                if (w_err) begin
                    w_good_next = '0;
                end else if (w_reload && !r_dirty) begin
                    w_good_next = w_good_inc;
                    if (w_good_inc == GOOD_TGT) begin
                        w_state_next = LOCKED;
                    end
                end else if (w_reload) begin
                    w_good_next = '0;
                end
            end
            LOCKED: begin
                if (w_err) begin
                    w_state_next = UNLOCKED;
                    w_good_next  = '0;
                end
            end
            default: begin
                w_state_next = UNLOCKED;
                w_good_next  = '0;
            end
        endcase
    end

    logic          w_locked_next;
    logic          w_hact;
    logic          w_vact;
    logic          w_de_next;
    logic [HW-1:0] w_x_next;
    logic [VW-1:0] w_y_next;
    logic          w_fs_next;

    assign w_locked_next = (w_state_next == LOCKED);
    assign w_hact        = (r_h_cnt >= H_ACT_LO) && (r_h_cnt <= H_ACT_HI);
    assign w_vact        = (r_v_cnt >= V_ACT_LO) && (r_v_cnt <= V_ACT_HI);
    assign w_de_next     = w_locked_next && w_hact && w_vact;
    assign w_x_next      = w_hact ? (r_h_cnt - H_ACT_LO) : '0;
    assign w_y_next      = w_vact ? (r_v_cnt - V_ACT_LO) : '0;
    assign w_fs_next     = w_de_next && (w_x_next == '0) && (w_y_next == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_v_pend  <= 1'b0;
            r_h_seen  <= 1'b0;
            r_v_seen  <= 1'b0;
            r_to_done <= 1'b0;
            r_dirty   <= 1'b0;
            r_good    <= '0;
            r_state   <= UNLOCKED;
            r_x       <= '0;
            r_y       <= '0;
            r_de      <= 1'b0;
            r_fs      <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Horizontal counter saturates so a missing hsync cannot wrap it.
            if (w_hedge) begin
                r_h_cnt  <= '0;
                r_h_seen <= 1'b1;
            end else if (r_h_cnt != H_MAX) begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            if (w_hedge) begin
                r_to_done <= 1'b0;
            end else if (w_h_timeout) begin
                r_to_done <= 1'b1;
            end

            if (w_reload) begin
                r_v_cnt  <= '0;
                r_v_pend <= 1'b0;
                r_v_seen <= 1'b1;
            end else begin
                if (w_hedge && (r_v_cnt != V_MAX)) begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
                if (w_vedge) begin
                    r_v_pend <= 1'b1;
                end
            end

            // An error on the reload edge itself belongs to the frame that ends.
            r_dirty  <= w_reload ? 1'b0 : (r_dirty || w_err);
            r_good   <= w_good_next;
            r_state  <= w_state_next;

            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_de     <= w_de_next;
            r_fs     <= w_fs_next;
            r_locked <= w_locked_next;
            r_err    <= w_err;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign de          = r_de;
    assign frame_start = r_fs;
    assign locked      = r_locked;
    assign sync_err    = r_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
// Drives a reduced VGA mode (16x8 visible, 25 clk/line, 13 lines/frame) into an
// active-low and an active-high instance. Each generated frame is one row of a
// table of expected per-frame results; a few hand-written checks cover output
// latency, the short-line error timing, the h timeout and a mid-frame reset.
// A generated frame starts with the hsync edge at which v_cnt reloads; vsync
// asserts mid-line (h=12) on the last line and is held for two lines.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;    // 25
    localparam int HW = 5;                    // $clog2(25)
    localparam int VW = 4;                    // $clog2(13)
    localparam int VS_H = 12;                 // h position of the vsync edge
    localparam int LOG_N = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hsync = 1'b1;
    logic vsync = 1'b1;
    logic hsync_p;
    logic vsync_p;

    logic [HW-1:0] x, x_p;
    logic [VW-1:0] y, y_p;
    logic de, de_p, frame_start, frame_start_p, locked, locked_p, sync_err, sync_err_p;

    assign hsync_p = ~hsync;
    assign vsync_p = ~vsync;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(0), .LOCK_FRAMES(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .de(de), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err)
    );

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1), .LOCK_FRAMES(2)
    ) u_dut_p (
        .clk(clk), .rst_n(rst_n), .hsync(hsync_p), .vsync(vsync_p),
        .x(x_p), .y(y_p), .de(de_p), .frame_start(frame_start_p),
        .locked(locked_p), .sync_err(sync_err_p)
    );

    typedef struct {
        int lines;      // lines in this frame
        int bad_line;   // line with non-standard length (-1: none)
        int bad_len;    // length of that line
        int rst_line;   // line with a 1-clk reset at h=3 (-1: none)
        int exp_err;    // sync_err pulses in the frame
        int exp_lock;   // locked at the end of the frame
        int exp_de;     // de-high clk in the frame
        int exp_fs;     // frame_start pulses in the frame
    } row_t;

    row_t rows[21];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fr_err, fr_de, fr_fs, pix, pix_bad, fr_err_cyc, p_err, p_de;
    int line_cyc[16];
    int rst_cyc = 0;

    logic [HW-1:0] log_x   [LOG_N];
    logic          log_de  [LOG_N];
    logic          log_err [LOG_N];
    logic          log_lock[LOG_N];
    logic          log_zero[LOG_N];   // every output of both instances is 0

    function automatic int ci(input int c);
        return (c < 0) ? 0 : ((c >= LOG_N) ? LOG_N - 1 : c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clk: drive pins after the falling edge, sample 1 time unit after the
    // rising edge that follows.
    task automatic step(input logic hs, input logic vs, input logic rn);
        @(negedge clk);
        hsync = hs;
        vsync = vs;
        rst_n = rn;
        @(posedge clk);
        cyc++;
        #1;
        log_x[ci(cyc)]    = x;
        log_de[ci(cyc)]   = de;
        log_err[ci(cyc)]  = sync_err;
        log_lock[ci(cyc)] = locked;
        log_zero[ci(cyc)] = ({x, y, de, frame_start, locked, sync_err} == '0) &&
                            ({x_p, y_p, de_p, frame_start_p, locked_p, sync_err_p} == '0);
        if (sync_err === 1'b1) begin
            fr_err++;
            if (fr_err_cyc < 0) fr_err_cyc = cyc;
        end
        if (frame_start === 1'b1) begin
            fr_fs++;
            pix = 0;
        end
        if (de === 1'b1) begin
            fr_de++;
            if (int'(x) != pix % HV || int'(y) != pix / HV) pix_bad++;
            pix++;
        end
        if (sync_err_p === 1'b1) p_err++;
        if (de_p === 1'b1) p_de++;
    endtask

    task automatic run_frame(input row_t r);
        fr_err = 0; fr_de = 0; fr_fs = 0; pix = 0; pix_bad = 0;
        fr_err_cyc = -1; p_err = 0; p_de = 0;
        for (int l = 0; l < r.lines; l++) begin
            int len;
            len = (l == r.bad_line) ? r.bad_len : HT;
            for (int h = 0; h < len; h++) begin
                logic hs, vs, rn;
                hs = (h < HS) ? 1'b0 : 1'b1;
                vs = ((l == r.lines - 1 && h >= VS_H) || l == 0 || (l == 1 && h < VS_H)) ? 1'b0 : 1'b1;
                rn = (l == r.rst_line && h == 3) ? 1'b0 : 1'b1;
                step(hs, vs, rn);
                if (h == 0 && l < 16) line_cyc[l] = cyc;
                if (!rn) rst_cyc = cyc;
            end
        end
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            run_frame(rows[i]);
            check($sformatf("row%0d sync_err count", i), fr_err, rows[i].exp_err);
            check($sformatf("row%0d locked", i), locked, rows[i].exp_lock);
            check($sformatf("row%0d de count", i), fr_de, rows[i].exp_de);
            check($sformatf("row%0d frame_start count", i), fr_fs, rows[i].exp_fs);
            check($sformatf("row%0d bad pixels", i), pix_bad, 0);
            check($sformatf("row%0d pol1 sync_err count", i), p_err, rows[i].exp_err);
            check($sformatf("row%0d pol1 de count", i), p_de, rows[i].exp_de);
            check($sformatf("row%0d pol1 locked", i), locked_p, rows[i].exp_lock);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;
        //           lines bad  len  rst  err lock de   fs
        rows[0]  = '{13, -1,  0, -1,  0, 0,   0, 0};  // reload 1 -> SEEK
        rows[1]  = '{13, -1,  0, -1,  0, 0,   0, 0};  // good = 1
        rows[2]  = '{13, -1,  0, -1,  0, 1, 128, 1};  // good = 2 -> LOCKED
        rows[3]  = '{13, -1,  0, -1,  0, 1, 128, 1};
        rows[4]  = '{13,  6, 24, -1,  1, 0,  48, 1};  // short line 6
        rows[5]  = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[6]  = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[7]  = '{13, -1,  0, -1,  0, 1, 128, 1};  // relocked
        rows[8]  = '{12, -1,  0, -1,  0, 1, 128, 1};  // 12-line frame
        rows[9]  = '{13, -1,  0, -1,  1, 0,   0, 0};  // frame error at reload
        rows[10] = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[11] = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[12] = '{13, -1,  0, -1,  0, 1, 128, 1};
        rows[13] = '{13,  6, 40, -1,  2, 0,  48, 1};  // timeout, then line error
        rows[14] = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[15] = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[16] = '{13, -1,  0, -1,  0, 1, 128, 1};
        rows[17] = '{13, -1,  0,  6,  0, 0,  32, 1};  // reset at line 6, h=3
        rows[18] = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[19] = '{13, -1,  0, -1,  0, 0,   0, 0};
        rows[20] = '{13, -1,  0, -1,  0, 1, 128, 1};

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        check("reset outputs zero", log_zero[ci(cyc)], 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);

        // Clean stream up to lock and one more locked frame
        run_rows(0, 3);

        // Latency on line 5 of the last frame: x=0 appears 7+2 clk after the
        // assertion sample, x=15 at 22+2, de drops at 23+2.
        e = line_cyc[5];
        check("latency de before start", log_de[ci(e + 8)], 1'b0);
        check("latency x first", log_x[ci(e + 9)], 0);
        check("latency de first", log_de[ci(e + 9)], 1'b1);
        check("latency x last", log_x[ci(e + 24)], 15);
        check("latency de last", log_de[ci(e + 24)], 1'b1);
        check("latency de end", log_de[ci(e + 25)], 1'b0);

        // Short line: error one clk after the line-7 assertion sample
        run_rows(4, 4);
        check("short line err cycle", fr_err_cyc, line_cyc[7] + 1);
        check("short line locked at err", log_lock[ci(fr_err_cyc)], 1'b0);
        check("short line locked before err", log_lock[ci(fr_err_cyc - 1)], 1'b1);

        run_rows(5, 12);

        // h timeout: h_cnt saturates 32 clk after the line-6 edge sample
        run_rows(13, 13);
        e = line_cyc[6];
        check("timeout err pulse", log_err[ci(e + 33)], 1'b1);
        check("timeout locked drop", log_lock[ci(e + 33)], 1'b0);
        check("timeout locked before", log_lock[ci(e + 32)], 1'b1);
        n = 0;
        for (int c = e + 1; c <= e + 39; c++) n += int'(log_err[ci(c)]);
        check("timeout single pulse", n, 1);

        run_rows(14, 16);

        // Mid-frame reset while locked
        run_rows(17, 17);
        check("midframe reset outputs zero", log_zero[ci(rst_cyc)], 1'b1);
        check("midframe reset was locked", log_lock[ci(rst_cyc - 1)], 1'b1);

        run_rows(18, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes hsync/vsync on the pixel clock and recovers pixel coordinates (x, y), display-enable and frame markers.
- Checks the measured line and frame timing against the parameterised mode and reports lock.
- Sits at the monitor/capture end of the VGA link, feeding frame-buffer writers and test checkers.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clk)
- H_SYNC, 96, hsync width (clk)
- H_BACK, 48, horizontal back porch (clk)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- LOCK_FRAMES, 2, consecutive clean frames required to declare lock

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- hsync  in  1  horizontal sync, synchronous to clk
- vsync  in  1  vertical sync, synchronous to clk
- x  out  HW  pixel column in active area, HW = $clog2(H_TOTAL)
- y  out  VW  pixel row in active area, VW = $clog2(V_TOTAL)
- de  out  1  display enable; high only for active pixels while locked
- frame_start  out  1  one-clk pulse with de on pixel (0,0)
- locked  out  1  timing matches the mode
- sync_err  out  1  one-clk pulse on any detected timing violation

Behaviour:
- Derived constants: H_TOTAL = sum of H_*, default 800; V_TOTAL = sum of V_*, default 525.
- Input stage: pins are registered into s1, then s2. Assertion edge = (s1==SYNC_POL) & (s2!=SYNC_POL).
- h_cnt (HW bits):
  - On an hsync edge, loads 0; otherwise increments.
  - Saturates at 2^HW-1. Reaching saturation is an h timeout.
- vsync handling: a vsync edge sets v_pend. At the next hsync edge (or a coincident one), v_cnt loads 0 and v_pend clears. Otherwise each hsync edge increments v_cnt, saturating at 2^VW-1.
- Line check: at each hsync edge, h_cnt != H_TOTAL-1 is a line error. The first hsync edge after reset is exempt.
- Frame check: when v_cnt reloads, v_cnt != V_TOTAL-1 is a frame error.
- Error reporting: line error, frame error or h timeout pulses sync_err for 1 clk. An h timeout pulses only once until the next hsync edge.
- Lock FSM:
  - UNLOCKED: stay here until the first v_cnt reload, then go to SEEK with good=0.
  - SEEK: at each reload, a frame with no errors since the previous reload does good++, otherwise good=0. When good reaches LOCK_FRAMES, go to LOCKED. Any error resets good=0.
  - LOCKED: any error returns the FSM to UNLOCKED.
  - locked = (state==LOCKED), registered. It falls on the clk after the error is detected.
- Active region:
  - hact = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1]
  - vact = v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1]
- Output register:
  - de <= locked_next & hact & vact
  - x <= h_cnt-(H_SYNC+H_BACK) when hact, else 0
  - y <= v_cnt-(V_SYNC+V_BACK) when vact, else 0
  - frame_start <= de_next & x_next==0 & y_next==0
- Latency: fixed 2 clk from the clk edge sampling a pin to the corresponding x/y/de update. For example, the pixel sampled 144 clk after the hsync assertion sample appears with x=0 two clk later.
- Reset (rst_n low at an edge): s1/s2 load the deasserted level; h_cnt=0, v_cnt=0, v_pend=0, good=0, state=UNLOCKED; x=0, y=0, de=0, frame_start=0, locked=0, sync_err=0.
  - Reset mid-frame discards all history. Lock requires a fresh LOCK_FRAMES+1 vsync edges.
- Sync held permanently asserted gives no edges, so h_cnt times out and the block unlocks.
- Mid-line vsync edge: handled by v_pend; no glitch on y.

Decomposition:
- vga_pkg: derived totals, HW/VW width functions, lock_state_e enum {UNLOCKED, SEEK, LOCKED}.
- Sub-module sync_edge_det: 2-flop register plus assertion-edge detect with a polarity parameter, instantiated for hsync and vsync.

Test Plan:
- Clean 640x480 stream from the timing generator, 4 frames: sync_err never pulses; locked rises after the 3rd vsync edge (LOCK_FRAMES=2); frame 4 has de high for 640x480 clk with x 0..639, y 0..479; exactly one frame_start per frame.
- Latency: after lock, the hsync assertion sample plus 144 clk must give x=0, de=1 two clk later; x=639 at +783, de=0 at +784.
- Short line (one line of 799 clk) while locked: sync_err pulses once at that hsync edge; locked=0 the next clk; de=0 until relock; relock after 2 clean frames plus a reload.
- Wrong frame length (524 lines): frame error at vsync reload, sync_err pulse, lock lost; 525-line frames afterward relock.
- hsync held deasserted for 2^HW clk: single sync_err at saturation, locked=0, h_cnt stays saturated; normal stream resumes and relocks.
- rst_n low for 1 clk mid-frame while locked: all outputs 0 the next clk; locked stays 0 until 3 clean vsync edges; SYNC_POL=1 build passes the same clean-stream test with inverted syncs.
